// File: rtl/multi_tick_divider.sv
// multi_tick_divider: NUM_CH independent programmable tick generators.
// Each channel counts 0..act_max, emits a one-cycle tick after the wrap and
// toggles a square wave on every tick. Terminal-count writes land in a shadow
// register and only take effect at a period boundary, so no runt periods.

module multi_tick_divider_ch #(
  parameter int unsigned             COUNT_WIDTH = 24,
  parameter logic [COUNT_WIDTH-1:0]  DEFAULT_MAX = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sync,
  input  logic                   wr_sel,
  input  logic [COUNT_WIDTH-1:0] wr_data,
  output logic                   tick,
  output logic                   sq
);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] act_max_q, act_max_d;
  logic [COUNT_WIDTH-1:0] pend_max_q, pend_max_d;
  logic                   pend_flag_q, pend_flag_d;
  logic                   tick_q, tick_d;
  logic                   sq_q, sq_d;
  logic                   wrap;
  logic                   apply;

  // Next-state: disable/sync/wrap are all safe points to adopt the shadow count.
  always_comb begin
    cnt_d       = cnt_q;
    act_max_d   = act_max_q;
    pend_max_d  = pend_max_q;
    pend_flag_d = pend_flag_q;
    tick_d      = 1'b0;
    sq_d        = sq_q;
    wrap        = (cnt_q == act_max_q);
    apply       = 1'b0;
    if (!en) begin
      cnt_d = '0;
      apply = 1'b1;
    end else if (sync) begin
      // sync wins over a coincident wrap: no tick, no sq toggle
      cnt_d = '0;
      apply = 1'b1;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      sq_d   = ~sq_q;
      apply  = 1'b1;
    end else begin
      cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
    // The shadow value seen here is the one from before this edge's write,
    // so a write on a boundary edge waits for the next boundary.
    if (apply && pend_flag_q) begin
      act_max_d   = pend_max_q;
      pend_flag_d = 1'b0;
    end
    if (wr_sel) begin
      pend_max_d  = wr_data;
      pend_flag_d = 1'b1;
    end
  end

  // State registers with synchronous reset back to the default period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      act_max_q   <= DEFAULT_MAX;
      pend_max_q  <= DEFAULT_MAX;
      pend_flag_q <= 1'b0;
      tick_q      <= 1'b0;
      sq_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      act_max_q   <= act_max_d;
      pend_max_q  <= pend_max_d;
      pend_flag_q <= pend_flag_d;
      tick_q      <= tick_d;
      sq_q        <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

module multi_tick_divider #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned DEFAULT_MAX = 6000000-1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      en,
  input  logic                   sync,
  input  logic                   wr_en,
  input  logic [SEL_WIDTH-1:0]   wr_ch,
  input  logic [COUNT_WIDTH-1:0] wr_data,
  output logic [NUM_CH-1:0]      tick,
  output logic [NUM_CH-1:0]      sq
);

  localparam logic [COUNT_WIDTH-1:0] DMAX = COUNT_WIDTH'(DEFAULT_MAX);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Selects outside 0..NUM_CH-1 match no channel and are dropped.
    logic wr_sel;
    assign wr_sel = wr_en && (32'(wr_ch) == 32'(i));

    multi_tick_divider_ch #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .DEFAULT_MAX (DMAX)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
      .tick    (tick[i]),
      .sq      (sq[i])
    );
  end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Bench for multi_tick_divider: expected tick edges (with sq level) are
// queued per channel by the stimulus; a negedge monitor matches DUT ticks.

module tb_multi_tick_divider;

  localparam int NUM_CH = 3;
  localparam int CW     = 8;
  localparam int SW     = 2;
  localparam int DMAX   = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              wr_en;
  logic [SW-1:0]     wr_ch;
  logic [CW-1:0]     wr_data;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int   at;
    logic s;
  } exp_t;

  exp_t exp_q [NUM_CH][$];

  multi_tick_divider #(
    .NUM_CH      (NUM_CH),
    .COUNT_WIDTH (CW),
    .SEL_WIDTH   (SW),
    .DEFAULT_MAX (DMAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .tick    (tick),
    .sq      (sq)
  );

  always #5 clk = ~clk;

  // edge counter: at the negedge after edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every observed tick must match the head of its channel queue
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      while (exp_q[c].size() > 0 && exp_q[c][0].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_tick ch%0d: no tick seen, required at edge %0d (now %0d)",
                 c, exp_q[c][0].at, cyc);
        void'(exp_q[c].pop_front());
      end
      if (tick[c] === 1'b1) begin
        checks++;
        if (exp_q[c].size() == 0 || exp_q[c][0].at != cyc) begin
          errors++;
          $display("FAIL unexpected_tick ch%0d: tick at edge %0d, required next at edge %0d",
                   c, cyc, (exp_q[c].size() == 0) ? -1 : exp_q[c][0].at);
        end else begin
          if (sq[c] !== exp_q[c][0].s) begin
            errors++;
            $display("FAIL sq_at_tick ch%0d edge %0d: got %b, required %b",
                     c, cyc, sq[c], exp_q[c][0].s);
          end
          void'(exp_q[c].pop_front());
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic push(input int c, input int at, input logic s);
    exp_t e;
    e.at = at;
    e.s  = s;
    exp_q[c].push_back(e);
  endtask

  task automatic chk(input string name, input logic [NUM_CH-1:0] act,
                     input logic [NUM_CH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // write lands on the next posedge
  task automatic wr(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = SW'(ch);
    wr_data = CW'(d);
    nxt();
    wr_en   = 1'b0;
  endtask

  int b;

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    repeat (3) nxt();
    chk("reset_tick", tick, 3'b000);
    chk("reset_sq",   sq,   3'b000);

    // default period 10: ticks at +10/+20/+30, sq 1,0,1
    b = cyc;
    rst = 1'b0; en = '1;
    for (int k = 1; k <= 3; k++)
      for (int c = 0; c < NUM_CH; c++) push(c, b + 10*k, logic'(k % 2));
    repeat (32) nxt();
    en = '0;
    nxt(); nxt();
    chk("disabled_sq_hold_1", sq, 3'b111);

    // ch1=2 and ch2=0 written while disabled, then enabled
    wr(1, 2);
    wr(2, 0);
    nxt();
    b = cyc;
    en = 3'b110;
    push(1, b + 3, 1'b0); push(1, b + 6, 1'b1); push(1, b + 9, 1'b0);
    for (int k = 1; k <= 10; k++) push(2, b + k, logic'((k % 2) == 0));
    repeat (10) nxt();
    en = '0;
    nxt(); nxt();
    chk("disabled_tick", tick, 3'b000);
    chk("disabled_sq_hold_2", sq, 3'b101);

    // ch0 max=9: mid-period write 3, then pending 5 and a wrap-edge write of 1
    b = cyc;
    en = 3'b001;
    push(0, b + 10, 1'b0); push(0, b + 14, 1'b1); push(0, b + 18, 1'b0);
    push(0, b + 22, 1'b1); push(0, b + 26, 1'b0); push(0, b + 32, 1'b1);
    push(0, b + 34, 1'b0); push(0, b + 36, 1'b1);
    repeat (4) nxt();
    wr(0, 3);              // edge b+5, counter mid-period
    repeat (17) nxt();
    wr(0, 5);              // edge b+23, pending
    repeat (2) nxt();
    wr(0, 1);              // edge b+26, exactly on a wrap
    repeat (10) nxt();
    en = '0;

    // all channels max=4, staggered enables, sync coinciding with a ch0 wrap
    wr(0, 4); wr(1, 4); wr(2, 4);
    nxt(); nxt();
    b = cyc;
    en = 3'b001; nxt();
    en = 3'b011; nxt();
    en = 3'b111;
    push(0, b + 5, 1'b0); push(0, b + 15, 1'b1); push(0, b + 20, 1'b0);
    push(1, b + 6, 1'b1); push(1, b + 15, 1'b0); push(1, b + 20, 1'b1);
    push(2, b + 7, 1'b0); push(2, b + 15, 1'b1); push(2, b + 20, 1'b0);
    repeat (7) nxt();
    sync = 1'b1;
    nxt();
    sync = 1'b0;
    chk("sync_tick", tick, 3'b000);
    chk("sync_sq_hold", sq, 3'b010);
    repeat (10) nxt();
    en = '0;

    // out-of-range channel select must not change any period
    wr(3, 0);
    nxt();
    b = cyc;
    en = '1;
    push(0, b + 5, 1'b1); push(0, b + 10, 1'b0);
    push(1, b + 5, 1'b0); push(1, b + 10, 1'b1);
    push(2, b + 5, 1'b1); push(2, b + 10, 1'b0);
    repeat (12) nxt();

    // reset mid-period: outputs clear, period reverts to default
    rst = 1'b1;
    nxt();
    chk("midreset_tick", tick, 3'b000);
    chk("midreset_sq",   sq,   3'b000);
    b = cyc;
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      push(c, b + 10, 1'b1);
      push(c, b + 20, 1'b0);
    end
    repeat (22) nxt();
    en = '0;
    repeat (3) nxt();

    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++;
        $display("FAIL drain ch%0d: %0d expected ticks left, required 0", c, exp_q[c].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
